// File: rtl/commit_lane_merge.sv
// Rebuilds full-warp commits from NUM_LANES-wide beats tagged pid/sop/eop.
// One partial instruction is accumulated; a separate output register holds the completed one.

module commit_lane_slot #(
  parameter int XLEN = 32
) (
  input  logic            base_mask,
  input  logic [XLEN-1:0] base_data,
  input  logic            wr_en,
  input  logic            wr_mask,
  input  logic [XLEN-1:0] wr_data,
  output logic            nxt_mask,
  output logic [XLEN-1:0] nxt_data
);
  logic hit;
  // Inactive lanes keep whatever an earlier beat left, so a repeated pid only overrides its active lanes.
  assign hit      = wr_en && wr_mask;
  assign nxt_mask = base_mask | hit;
  assign nxt_data = hit ? wr_data : base_data;
endmodule

module commit_lane_merge #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int META_W      = 64,
  parameter int PID_W       = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [META_W-1:0]           in_meta,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_W-1:0]            in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [META_W-1:0]           out_meta,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        err
);
  localparam int NUM_SLOTS = NUM_THREADS / NUM_LANES;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                                state;
  logic [META_W-1:0]                     acc_meta;
  logic [NUM_THREADS-1:0]                acc_tmask;
  logic [NUM_THREADS-1:0][XLEN-1:0]      acc_data;
  logic [NUM_SLOTS-1:0]                  written;
  logic [NUM_THREADS-1:0][XLEN-1:0]      out_data_q;

  logic [NUM_LANES-1:0][XLEN-1:0]        in_lane;
  logic [NUM_THREADS-1:0]                base_mask, nxt_mask;
  logic [NUM_THREADS-1:0][XLEN-1:0]      base_data, nxt_data;
  logic [NUM_SLOTS-1:0]                  slot_hit, nxt_written;
  logic [PID_W:0]                        pid_ext;
  logic fire, pid_ok, start, cont, orphan, wr, done, dup, meta_bad, err_set;

  assign in_lane  = in_data;
  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign pid_ext  = {1'b0, in_pid};
  assign pid_ok   = pid_ext < (PID_W+1)'(NUM_SLOTS);

  assign start  = fire && in_sop;
  assign cont   = fire && !in_sop && (state == ACCUM);
  assign orphan = fire && !in_sop && (state == IDLE);
  assign wr     = start || cont;
  assign done   = wr && in_eop;

  // A sop beat starts from an empty accumulator, discarding any partial instruction.
  assign base_mask = start ? '0 : acc_tmask;
  assign base_data = start ? '0 : acc_data;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign slot_hit[s] = pid_ok && (in_pid == PID_W'(s));
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    commit_lane_slot #(.XLEN(XLEN)) u_slot (
      .base_mask (base_mask[t]),
      .base_data (base_data[t]),
      .wr_en     (wr && slot_hit[t / NUM_LANES]),
      .wr_mask   (in_tmask[t % NUM_LANES]),
      .wr_data   (in_lane[t % NUM_LANES]),
      .nxt_mask  (nxt_mask[t]),
      .nxt_data  (nxt_data[t])
    );
  end

  assign nxt_written = (start ? '0 : written) | slot_hit;
  assign dup         = cont && |(written & slot_hit);
  assign meta_bad    = cont && (in_meta != acc_meta);
  assign err_set     = orphan || (start && state == ACCUM) || meta_bad || (wr && !pid_ok) || dup;

  assign out_data = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc_meta   <= '0;
      acc_tmask  <= '0;
      acc_data   <= '0;
      written    <= '0;
      out_valid  <= 1'b0;
      out_meta   <= '0;
      out_tmask  <= '0;
      out_data_q <= '0;
      err        <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (wr) begin
        acc_tmask <= nxt_mask;
        acc_data  <= nxt_data;
        written   <= nxt_written;
        if (start) acc_meta <= in_meta;
        state <= in_eop ? IDLE : ACCUM;
      end
      // in_ready guarantees the output slot is free or draining whenever done is set.
      if (done) begin
        out_valid  <= 1'b1;
        out_tmask  <= nxt_mask;
        out_data_q <= nxt_data;
        out_meta   <= start ? in_meta : acc_meta;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_commit_lane_merge.sv
// Directed vector table plus randomized beats against a spec-level merge model.
module tb_commit_lane_merge;
  localparam int NT = 4, NL = 2, XL = 32, MW = 64, PW = 1, SLOTS = NT / NL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
  logic [MW-1:0] in_meta = '0;
  logic [NL-1:0] in_tmask = '0;
  logic [NL*XL-1:0] in_data = '0;
  logic [PW-1:0] in_pid = '0;
  logic out_valid, out_ready = 1'b1, err;
  logic [MW-1:0] out_meta;
  logic [NT-1:0] out_tmask;
  logic [NT*XL-1:0] out_data;

  int checks = 0, failures = 0;

  commit_lane_merge #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .META_W(MW), .PID_W(PW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta), .out_tmask(out_tmask),
    .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, v, sop, eop, ordy;
    logic [PW-1:0] pid;
    logic [NL-1:0] tm;
    logic [63:0] dat, meta;
    logic e_ir, e_ov, e_err, e_chk;
    logic [3:0] e_tm;
    logic [127:0] e_dat;
    logic [63:0] e_meta;
  } vec_t;

  function automatic vec_t mk(input logic rst, v, sop, eop, input logic [PW-1:0] pid,
                              input logic [1:0] tm, input logic [63:0] dat, meta, input logic ordy,
                              input logic e_ir, e_ov, input logic [3:0] e_tm, input logic e_err,
                              input logic e_chk, input logic [127:0] e_dat, input logic [63:0] e_meta);
    vec_t r;
    r.rst = rst; r.v = v; r.sop = sop; r.eop = eop; r.pid = pid; r.tm = tm; r.dat = dat;
    r.meta = meta; r.ordy = ordy; r.e_ir = e_ir; r.e_ov = e_ov; r.e_tm = e_tm; r.e_err = e_err;
    r.e_chk = e_chk; r.e_dat = e_dat; r.e_meta = e_meta;
    return r;
  endfunction

  // Spec-level model state for the randomized phase.
  logic [195:0] q[$];
  logic m_part, m_err;
  logic [MW-1:0] m_meta;
  logic [NT-1:0] m_mask;
  logic [NT-1:0][XL-1:0] m_data;
  logic [SLOTS-1:0] m_seen;

  task automatic m_beat();
    int p;
    p = int'(in_pid);
    if (in_sop) begin
      if (m_part) m_err = 1'b1;
      m_part = 1'b1; m_meta = in_meta; m_mask = '0; m_data = '0; m_seen = '0;
    end else if (!m_part) begin
      m_err = 1'b1;
      return;
    end else if (in_meta != m_meta) begin
      m_err = 1'b1;
    end
    if (p >= SLOTS) m_err = 1'b1;
    else begin
      if (!in_sop && m_seen[p]) m_err = 1'b1;
      m_seen[p] = 1'b1;
      for (int i = 0; i < NL; i++)
        if (in_tmask[i]) begin
          m_mask[p*NL+i] = 1'b1;
          m_data[p*NL+i] = in_data[i*XL +: XL];
        end
    end
    if (in_eop) begin
      q.push_back({m_meta, m_mask, m_data});
      m_part = 1'b0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic hold, m_rdy;
    int gp;
    logic [MW-1:0] g_meta;
    // rst v sop eop pid tm dat meta ordy | ir ov tm err chk dat meta
    tbl.push_back(mk(1,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,0,1,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,0,0,2'b11,64'h00000011_00000010,64'hA,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,0,1,1,2'b01,64'hDEADBEEF_00000012,64'hA,1, 1,1,4'b0111,0,1,
                     128'h00000000_00000012_00000011_00000010,64'hA));
    tbl.push_back(mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,0,0,2'b10,64'h00000021_00000020,64'hC,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,0,1,1,2'b11,64'h00000023_00000022,64'hC,0, 1,1,4'b1110,0,1,
                     128'h00000023_00000022_00000021_00000000,64'hC));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,1,1,1,0,2'b11,64'h00000031_00000030,64'hD,0, 0,1,4'b1110,0,1,
                       128'h00000023_00000022_00000021_00000000,64'hC));
    tbl.push_back(mk(0,1,1,1,0,2'b11,64'h00000031_00000030,64'hD,1, 1,1,4'b0011,0,1,
                     128'h00000000_00000000_00000031_00000030,64'hD));
    tbl.push_back(mk(0,1,1,0,0,2'b11,64'h00000041_00000040,64'hE,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,0,1,1,2'b11,64'h00000043_00000042,64'hE,1, 1,1,4'b1111,0,1,
                     128'h00000043_00000042_00000041_00000040,64'hE));
    tbl.push_back(mk(0,1,1,0,0,2'b01,64'h00000099_00000050,64'hF,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,0,1,1,2'b10,64'h00000053_00000077,64'hF,1, 1,1,4'b1001,0,1,
                     128'h00000053_00000000_00000000_00000050,64'hF));
    tbl.push_back(mk(0,1,0,1,1,2'b11,64'h00000061_00000060,64'h6,1, 1,0,4'b0000,1,0,128'h0,64'h0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,1,0,128'h0,64'h0));
    tbl.push_back(mk(1,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,0,1,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,0,0,2'b11,64'h00000071_00000070,64'hA,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,1,0,2'b01,64'h00000073_00000072,64'hB,1, 1,1,4'b0001,1,1,
                     128'h00000000_00000000_00000000_00000072,64'hB));
    tbl.push_back(mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,1,0,128'h0,64'h0));
    tbl.push_back(mk(1,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,0,0,2'b11,64'h00000081_00000080,64'hA,1, 1,0,4'b0000,0,0,128'h0,64'h0));
    tbl.push_back(mk(1,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,0,1,128'h0,64'h0));
    tbl.push_back(mk(0,1,0,1,1,2'b11,64'h00000083_00000082,64'hA,1, 1,0,4'b0000,1,0,128'h0,64'h0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,64'h0,64'h0,1, 1,0,4'b0000,1,0,128'h0,64'h0));
    tbl.push_back(mk(0,1,1,1,0,2'b11,64'h00000091_00000090,64'hA,0, 1,1,4'b0011,1,1,
                     128'h00000000_00000000_00000091_00000090,64'hA));
    tbl.push_back(mk(1,0,0,0,0,2'b00,64'h0,64'h0,0, 0,0,4'b0000,0,1,128'h0,64'h0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,64'h0,64'h0,0, 1,0,4'b0000,0,0,128'h0,64'h0));

    foreach (tbl[k]) begin
      @(negedge clk);
      reset = tbl[k].rst; in_valid = tbl[k].v; in_sop = tbl[k].sop; in_eop = tbl[k].eop;
      in_pid = tbl[k].pid; in_tmask = tbl[k].tm; in_data = tbl[k].dat; in_meta = tbl[k].meta;
      out_ready = tbl[k].ordy;
      #1 chk($sformatf("v%0d_in_ready", k), in_ready, tbl[k].e_ir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", k), out_valid, tbl[k].e_ov);
      chk($sformatf("v%0d_err", k), err, tbl[k].e_err);
      if (tbl[k].e_chk) begin
        chk($sformatf("v%0d_out_tmask", k), out_tmask, tbl[k].e_tm);
        chk($sformatf("v%0d_out_data", k), out_data, tbl[k].e_dat);
        chk($sformatf("v%0d_out_meta", k), out_meta, tbl[k].e_meta);
      end
    end

    // Randomized phase.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); m_part = 1'b0; m_err = 1'b0; m_mask = '0; m_data = '0; m_seen = '0; m_meta = '0;
    hold = 1'b0; gp = 0; g_meta = '0;
    for (int c = 0; c < 4000; c++) begin
      if (c != 0) @(negedge clk);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      chk("rnd_err", err, m_err);
      if (q.size() != 0) chk("rnd_out", {out_meta, out_tmask, out_data}, q[0]);
      if (!hold) begin
        in_valid = ($urandom % 4) != 0;
        if ($urandom % 16 == 0) begin
          in_sop = $urandom; in_eop = $urandom; in_pid = PW'($urandom);
          in_meta = ($urandom % 2) ? g_meta : {32'h0, $urandom};
        end else begin
          if (gp == 0) g_meta = {$urandom, $urandom};
          in_sop = (gp == 0); in_pid = PW'(gp); in_meta = g_meta;
          in_eop = (gp == SLOTS - 1) || ($urandom % 5 == 0);
        end
        in_tmask = NL'($urandom);
        in_data = {$urandom, $urandom};
      end
      out_ready = ($urandom % 4) != 0;
      #1;
      m_rdy = (q.size() == 0) || out_ready;
      chk("rnd_in_ready", in_ready, m_rdy);
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && m_rdy) begin
        m_beat();
        gp = in_eop ? 0 : (gp + 1) % SLOTS;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
